// File: rtl/image_set_regfile_if.sv
`default_nettype none
// ============================================================================
// image_set_regfile_if : register-file read/write bus for image_set_regfile
// Revision: 1.0
// ============================================================================
interface image_set_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_data, rd_valid
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output rd_data, rd_valid
    );
endinterface
`default_nettype wire

// File: rtl/image_set_regfile.sv
`default_nettype none
// ============================================================================
// image_set_regfile : CTRL/STATUS/CFG registers and start/done FSM for an image engine
// Revision: 1.0
// ============================================================================
module image_set_regfile #(
    parameter int DATA_W = 32,
    parameter int N_REGS = 8,
    parameter int ADDR_W = 3
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    image_set_regfile_if.slave              bus,
    input  wire logic                       accel_done,
    output logic                            start_pulse,
    output logic                            busy,
    output logic                            irq,
    output logic [(N_REGS-2)*DATA_W-1:0]    cfg_flat
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic              irq_en, irq_en_nx;
    logic              done, done_nx;
    logic              err, err_nx;
    logic              start_nx;
    logic [DATA_W-1:0] cfg [2:N_REGS-1];
    logic [DATA_W-1:0] rd_mux;
    int unsigned       wa, ra;
    logic              ctrl_wr, status_wr, cfg_wr;

    assign wa        = 32'(bus.wr_addr);
    assign ra        = 32'(bus.rd_addr);
    assign ctrl_wr   = bus.wr_en && (wa == 32'd0);
    assign status_wr = bus.wr_en && (wa == 32'd1);
    assign cfg_wr    = bus.wr_en && (wa >= 32'd2) && (wa < 32'(N_REGS));
    assign busy      = (state == BUSY);

    always_comb begin
        state_nx  = state;
        done_nx   = done;
        err_nx    = err;
        irq_en_nx = irq_en;
        start_nx  = 1'b0;
        if (ctrl_wr) begin
            irq_en_nx = bus.wr_data[1];
            if (bus.wr_data[0]) begin
                if (state == BUSY) begin
                    err_nx = 1'b1;
                end else begin
                    state_nx = BUSY;
                    start_nx = 1'b1;
                    done_nx  = 1'b0;
                end
            end
        end
        if (status_wr) begin
            if (bus.wr_data[1]) begin
                done_nx = 1'b0;
                if (state == DONE) state_nx = IDLE;
            end
            if (bus.wr_data[2]) err_nx = 1'b0;
        end
        if (cfg_wr && state == BUSY) err_nx = 1'b1;
        // Completion wins over a colliding start write; the start only flags err.
        if (accel_done && state == BUSY) begin
            state_nx = DONE;
            done_nx  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            irq_en      <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            start_pulse <= 1'b0;
            irq         <= 1'b0;
        end else begin
            state       <= state_nx;
            irq_en      <= irq_en_nx;
            done        <= done_nx;
            err         <= err_nx;
            start_pulse <= start_nx;
            irq         <= done & irq_en;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 2; i < N_REGS; i++) begin
            if (!rst) begin
                cfg[i] <= '0;
            end else if (cfg_wr && state != BUSY && wa == 32'(i)) begin
                cfg[i] <= bus.wr_data;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        if (ra == 32'd0) begin
            rd_mux[1] = irq_en;
        end else if (ra == 32'd1) begin
            rd_mux[2:0] = {err, done, busy};
        end else begin
            for (int i = 2; i < N_REGS; i++) begin
                if (ra == 32'(i)) rd_mux = cfg[i];
            end
        end
    end

    // Read mux sees pre-write register values, so same-cycle read/write returns old data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.rd_data  <= '0;
            bus.rd_valid <= 1'b0;
        end else begin
            bus.rd_valid <= bus.rd_en;
            if (bus.rd_en) bus.rd_data <= rd_mux;
        end
    end

    always_comb begin
        cfg_flat = '0;
        for (int i = 2; i < N_REGS; i++) begin
            cfg_flat[(i-2)*DATA_W +: DATA_W] = cfg[i];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_image_set_regfile.sv
`default_nettype none
// ============================================================================
// tb_image_set_regfile : directed + model-checked bench for image_set_regfile
// Revision: 1.0
// ============================================================================
module tb_image_set_regfile;
    localparam int DW  = 32;
    localparam int AW  = 3;
    localparam int NR  = 8;
    localparam int NR6 = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst;
    logic                   accel_done, accel6;
    logic                   start_pulse, busy, irq;
    logic [(NR-2)*DW-1:0]   cfg_flat;
    logic                   start6, busy6, irq6;
    logic [(NR6-2)*DW-1:0]  cfg_flat6;

    image_set_regfile_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    image_set_regfile_if #(.DATA_W(DW), .ADDR_W(AW)) bus6 ();

    image_set_regfile #(.DATA_W(DW), .N_REGS(NR), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .bus(bus), .accel_done(accel_done),
        .start_pulse(start_pulse), .busy(busy), .irq(irq), .cfg_flat(cfg_flat)
    );

    image_set_regfile #(.DATA_W(DW), .N_REGS(NR6), .ADDR_W(AW)) dut6 (
        .clk(clk), .rst(rst), .bus(bus6), .accel_done(accel6),
        .start_pulse(start6), .busy(busy6), .irq(irq6), .cfg_flat(cfg_flat6)
    );

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Behavioural model: mst 0=idle 1=running 2=finished
    int          mst;
    bit          m_done, m_err, m_irq_en;
    logic [31:0] m_cfg [8];
    logic [31:0] m_rd_data;
    bit          m_rd_valid, m_start, m_irq;

    function automatic logic [31:0] m_read(input int a);
        if (a == 0)      return {30'b0, m_irq_en, 1'b0};
        else if (a == 1) return {29'b0, m_err, m_done, (mst == 1)};
        else if (a < NR) return m_cfg[a];
        return 32'h0;
    endfunction

    function automatic logic [(NR-2)*DW-1:0] m_flat();
        logic [(NR-2)*DW-1:0] f;
        f = '0;
        for (int i = 2; i < NR; i++) f[(i-2)*DW +: DW] = m_cfg[i];
        return f;
    endfunction

    always @(posedge clk) begin : model
        int          wa, ra;
        bit          was_busy;
        logic [31:0] wd;
        if (!rst) begin
            mst = 0; m_done = 0; m_err = 0; m_irq_en = 0;
            for (int i = 0; i < 8; i++) m_cfg[i] = 32'h0;
            m_rd_data = 32'h0; m_rd_valid = 0; m_start = 0; m_irq = 0;
        end else begin
            wa = int'(bus.wr_addr);
            ra = int'(bus.rd_addr);
            wd = bus.wr_data;
            m_irq      = m_done & m_irq_en;
            m_rd_valid = bus.rd_en;
            if (bus.rd_en) m_rd_data = m_read(ra);
            was_busy = (mst == 1);
            m_start  = 0;
            if (bus.wr_en) begin
                if (wa == 0) begin
                    m_irq_en = wd[1];
                    if (wd[0]) begin
                        if (was_busy) m_err = 1;
                        else begin mst = 1; m_start = 1; m_done = 0; end
                    end
                end else if (wa == 1) begin
                    if (wd[1]) begin m_done = 0; if (mst == 2) mst = 0; end
                    if (wd[2]) m_err = 0;
                end else if (wa < NR) begin
                    if (was_busy) m_err = 1;
                    else m_cfg[wa] = wd;
                end
            end
            if (accel_done && was_busy) begin mst = 2; m_done = 1; end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("rd_valid", bus.rd_valid, m_rd_valid);
            chk("rd_data", bus.rd_data, m_rd_data);
            chk("start_pulse", start_pulse, m_start);
            chk("busy", busy, (mst == 1));
            chk("irq", irq, m_irq);
            chk("cfg_flat", cfg_flat, m_flat());
        end
    end

    task automatic cyc(input bit we, input int wa, input logic [31:0] wd,
                       input bit re, input int ra, input bit ad);
        bus.wr_en = we; bus.wr_addr = AW'(wa); bus.wr_data = wd;
        bus.rd_en = re; bus.rd_addr = AW'(ra); accel_done = ad;
        @(posedge clk); #1;
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; accel_done = 1'b0;
    endtask

    task automatic cyc6(input bit we, input int wa, input logic [31:0] wd,
                        input bit re, input int ra);
        bus6.wr_en = we; bus6.wr_addr = AW'(wa); bus6.wr_data = wd;
        bus6.rd_en = re; bus6.rd_addr = AW'(ra);
        @(posedge clk); #1;
        bus6.wr_en = 1'b0; bus6.rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b0; accel_done = 1'b0; accel6 = 1'b0;
        bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.rd_en = 0; bus.rd_addr = '0;
        bus6.wr_en = 0; bus6.wr_addr = '0; bus6.wr_data = '0; bus6.rd_en = 0; bus6.rd_addr = '0;
        repeat (2) begin @(posedge clk); #1; end
        chk_on = 1'b1;
        rst = 1'b1;
        chk("rst busy", busy, 1'b0);
        chk("rst irq", irq, 1'b0);
        chk("rst start", start_pulse, 1'b0);
        chk("rst rd_valid", bus.rd_valid, 1'b0);
        chk("rst rd_data", bus.rd_data, 32'h0);
        chk("rst cfg_flat", cfg_flat, 192'h0);

        // Status read after reset
        cyc(0, 0, 0, 1, 1, 0);
        chk("status0 valid", bus.rd_valid, 1'b1);
        chk("status0 data", bus.rd_data, 32'h0);

        // Same-cycle write/read of CFG returns old value
        cyc(1, 2, 32'hA5A5_0001, 1, 2, 0);
        chk("cfg2 rd same", bus.rd_data, 32'h0);
        chk("cfg2 flat", cfg_flat[31:0], 32'hA5A5_0001);
        cyc(0, 0, 0, 1, 2, 0);
        chk("cfg2 rd next", bus.rd_data, 32'hA5A5_0001);

        // Start / done / irq / clear
        cyc(1, 0, 32'h3, 0, 0, 0);
        chk("start pulse", start_pulse, 1'b1);
        chk("start busy", busy, 1'b1);
        cyc(0, 0, 0, 1, 1, 0);
        chk("start once", start_pulse, 1'b0);
        chk("status busy", bus.rd_data, 32'h1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("done busy", busy, 1'b0);
        chk("irq lag", irq, 1'b0);
        cyc(0, 0, 0, 1, 1, 0);
        chk("status done", bus.rd_data, 32'h2);
        chk("irq set", irq, 1'b1);
        cyc(1, 1, 32'h2, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);
        chk("status clr", bus.rd_data, 32'h0);
        chk("irq clr", irq, 1'b0);

        // Writes while running are refused and flag err
        cyc(1, 0, 32'h1, 0, 0, 0);
        cyc(1, 3, 32'hFFFF, 0, 0, 0);
        cyc(1, 0, 32'h1, 0, 0, 0);
        chk("busy restart", start_pulse, 1'b0);
        cyc(0, 0, 0, 1, 1, 0);
        chk("status err", bus.rd_data, 32'h5);
        chk("cfg3 kept", cfg_flat[63:32], 32'h0);
        cyc(1, 1, 32'h4, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);
        chk("err clr", bus.rd_data, 32'h1);

        // Start write colliding with completion
        cyc(1, 0, 32'h1, 0, 0, 1);
        chk("collide busy", busy, 1'b0);
        cyc(0, 0, 0, 1, 1, 0);
        chk("collide status", bus.rd_data, 32'h6);
        cyc(1, 1, 32'h6, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);
        chk("collide clr", bus.rd_data, 32'h0);

        // Fill CFG, CTRL readback masking
        for (int i = 2; i < NR; i++) cyc(1, i, 32'h1000_0000 + 32'(i) * 32'h111, 0, 0, 0);
        chk("cfg7 flat", cfg_flat[191:160], 32'h1000_0777);
        cyc(1, 0, 32'hFFFF_FFFE, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("ctrl rb", bus.rd_data, 32'h2);

        // Model-checked mixed traffic
        for (int n = 0; n < 80; n++) begin
            cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom,
                1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                ($urandom_range(0, 3) == 0));
        end
        cyc(1, 1, 32'h6, 0, 0, 0);

        // Reset during a run with a concurrent completion
        cyc(1, 0, 32'h3, 0, 0, 0);
        chk("pre-rst busy", busy, 1'b1);
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0, 1);
        rst = 1'b1;
        chk("rst-run busy", busy, 1'b0);
        chk("rst-run irq", irq, 1'b0);
        chk("rst-run start", start_pulse, 1'b0);
        chk("rst-run cfg", cfg_flat, 192'h0);
        cyc(0, 0, 0, 1, 1, 0);
        chk("rst-run status", bus.rd_data, 32'h0);
        chk("rst-run irq2", irq, 1'b0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 1, 0);
        chk("idle done ign", bus.rd_data, 32'h0);

        // Out-of-range access on the 6-register build
        cyc6(1, 2, 32'h1234, 0, 0);
        cyc6(0, 0, 0, 1, 2);
        chk("n6 cfg2", bus6.rd_data, 32'h1234);
        cyc6(1, 7, 32'hDEAD, 0, 0);
        cyc6(1, 6, 32'hBEEF, 0, 0);
        cyc6(0, 0, 0, 1, 7);
        chk("n6 oor valid", bus6.rd_valid, 1'b1);
        chk("n6 oor data", bus6.rd_data, 32'h0);
        chk("n6 flat", cfg_flat6, {96'h0, 32'h1234});
        cyc6(0, 0, 0, 1, 1);
        chk("n6 status", bus6.rd_data, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
